// File: rtl/sevenseg_pkg.sv
// Purpose: shared constants and types for the seven-segment scan driver.
// Latency: n/a (types, constants and the hex font only).
// Backpressure: n/a.
package sevenseg_pkg;

    localparam int SEG_W = 7;

    // Bit position of each segment within the segment vector.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t M_A = seg_t'(1) << SEG_A;
    localparam seg_t M_B = seg_t'(1) << SEG_B;
    localparam seg_t M_C = seg_t'(1) << SEG_C;
    localparam seg_t M_D = seg_t'(1) << SEG_D;
    localparam seg_t M_E = seg_t'(1) << SEG_E;
    localparam seg_t M_F = seg_t'(1) << SEG_F;
    localparam seg_t M_G = seg_t'(1) << SEG_G;

    // Active-high hex font, index = nibble value.
    localparam seg_t HEX_FONT [16] = '{
        M_A | M_B | M_C | M_D | M_E | M_F,          // 0
        M_B | M_C,                                  // 1
        M_A | M_B | M_D | M_E | M_G,                // 2
        M_A | M_B | M_C | M_D | M_G,                // 3
        M_B | M_C | M_F | M_G,                      // 4
        M_A | M_C | M_D | M_F | M_G,                // 5
        M_A | M_C | M_D | M_E | M_F | M_G,          // 6
        M_A | M_B | M_C,                            // 7
        M_A | M_B | M_C | M_D | M_E | M_F | M_G,    // 8
        M_A | M_B | M_C | M_D | M_F | M_G,          // 9
        M_A | M_B | M_C | M_E | M_F | M_G,          // A
        M_C | M_D | M_E | M_F | M_G,                // b
        M_A | M_D | M_E | M_F,                      // C
        M_B | M_C | M_D | M_E | M_G,                // d
        M_A | M_D | M_E | M_F | M_G,                // E
        M_A | M_E | M_F | M_G                       // F
    };

    typedef enum logic {
        SLOT_DEAD = 1'b0,
        SLOT_ON   = 1'b1
    } slot_state_t;

endpackage

// File: rtl/sevenseg_hex_font.sv
// Purpose: hex nibble to active-high seven-segment pattern.
// Latency: combinational.
// Backpressure: none.
module sevenseg_hex_font
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       pattern
);

    // Plain table lookup; output polarity is handled by the caller.
    always_comb begin
        pattern = HEX_FONT[nibble];
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Purpose: time-multiplexed hex scanner with double-buffered display word.
// Latency: pins registered, 1 cycle after scan state; new word shown within 2 frames.
// Backpressure: in_ready low while a word is pending; pending drains at frame boundary.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int PRESCALE       = 3000,
    parameter int DEAD_CYCLES    = 12,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int EN_ACTIVE_LOW  = 0
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*N_DIGITS-1:0] in_value,
    input  logic [N_DIGITS-1:0]   in_dp,
    input  logic [N_DIGITS-1:0]   in_blank,
    output logic [SEG_W-1:0]      sevenseg_segment,
    output logic                  sevenseg_dp,
    output logic [N_DIGITS-1:0]   sevenseg_enable,
    output logic                  frame_tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_ON   = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    // Inactive pin levels; XOR with these converts active-high to pin polarity.
    localparam logic                DP_OFF  = 1'(SEG_ACTIVE_LOW != 0);
    localparam seg_t                SEG_OFF = {SEG_W{DP_OFF}};
    localparam logic                EN_LOW  = 1'(EN_ACTIVE_LOW != 0);
    localparam logic [N_DIGITS-1:0] EN_OFF  = {N_DIGITS{EN_LOW}};

    logic [CNT_W-1:0]      cnt_q, cnt_nxt;
    logic [IDX_W-1:0]      idx_q, idx_nxt;
    slot_state_t           st_q, st_nxt;

    logic                  slot_end;
    logic                  frame_end;
    logic                  accept;
    logic                  commit;

    logic                  pend_full_q, pend_full_nxt;
    logic [4*N_DIGITS-1:0] pend_value_q;
    logic [N_DIGITS-1:0]   pend_dp_q;
    logic [N_DIGITS-1:0]   pend_blank_q;
    logic [4*N_DIGITS-1:0] act_value_q;
    logic [N_DIGITS-1:0]   act_dp_q;
    logic [N_DIGITS-1:0]   act_blank_q;

    logic [3:0]            cur_nibble;
    seg_t                  cur_pattern;
    logic [N_DIGITS-1:0]   digit_onehot;

    seg_t                  seg_nxt;
    logic                  dp_nxt;
    logic [N_DIGITS-1:0]   en_nxt;

    assign slot_end     = (cnt_q == CNT_LAST);
    assign frame_end    = slot_end && (idx_q == IDX_LAST);
    assign accept       = in_valid && in_ready;
    assign commit       = frame_end && pend_full_q;
    assign cur_nibble   = act_value_q[{idx_q, 2'b00} +: 4];
    assign digit_onehot = N_DIGITS'(1) << idx_q;

    sevenseg_hex_font u_font (
        .nibble  (cur_nibble),
        .pattern (cur_pattern)
    );

    // Prescaler, digit index and slot phase for the next cycle.
    always_comb begin
        cnt_nxt = cnt_q + CNT_W'(1);
        idx_nxt = idx_q;
        st_nxt  = st_q;
        if (slot_end) begin
            cnt_nxt = '0;
            idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        case (st_q)
            SLOT_DEAD: if (cnt_nxt == CNT_ON) st_nxt = SLOT_ON;
            SLOT_ON:   if (slot_end)          st_nxt = SLOT_DEAD;
            default:                          st_nxt = SLOT_DEAD;
        endcase
    end

    // Pin values for the next cycle; a blanked digit keeps its enable but goes dark.
    always_comb begin
        en_nxt  = EN_OFF;
        seg_nxt = SEG_OFF;
        dp_nxt  = DP_OFF;
        if (st_q == SLOT_ON) begin
            en_nxt = digit_onehot ^ EN_OFF;
            if (!act_blank_q[idx_q]) begin
                seg_nxt = cur_pattern ^ SEG_OFF;
                dp_nxt  = act_dp_q[idx_q] ^ DP_OFF;
            end
        end
    end

    // Pending occupancy: accept only when empty, commit only when full.
    always_comb begin
        pend_full_nxt = pend_full_q;
        if (accept) begin
            pend_full_nxt = 1'b1;
        end else if (commit) begin
            pend_full_nxt = 1'b0;
        end
    end

    // Scan state registers.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            st_q  <= SLOT_DEAD;
        end else begin
            cnt_q <= cnt_nxt;
            idx_q <= idx_nxt;
            st_q  <= st_nxt;
        end
    end

    // Double buffer: pending fills on handshake, active reloads only at frame end.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            pend_full_q  <= 1'b0;
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            act_value_q  <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
            in_ready     <= 1'b0;
        end else begin
            pend_full_q <= pend_full_nxt;
            in_ready    <= !pend_full_nxt;
            if (accept) begin
                pend_value_q <= in_value;
                pend_dp_q    <= in_dp;
                pend_blank_q <= in_blank;
            end
            if (commit) begin
                act_value_q <= pend_value_q;
                act_dp_q    <= pend_dp_q;
                act_blank_q <= pend_blank_q;
            end
        end
    end

    // Registered pins and frame pulse.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sevenseg_segment <= SEG_OFF;
            sevenseg_dp      <= DP_OFF;
            sevenseg_enable  <= EN_OFF;
            frame_tick       <= 1'b0;
        end else begin
            sevenseg_segment <= seg_nxt;
            sevenseg_dp      <= dp_nxt;
            sevenseg_enable  <= en_nxt;
            frame_tick       <= frame_end;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Purpose: directed self-checking bench for sevenseg_scan_driver (4 digits, 8-cycle slots, 2 dead).
// Latency: cycle t counts from the first cycle after the reset edge; pins show scan state of t-1.
// Backpressure: words are offered on fixed cycles and held until the expected accept cycle.
module tb_sevenseg_scan_driver;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_value;
    logic [3:0]  in_dp;
    logic [3:0]  in_blank;
    logic [6:0]  sevenseg_segment;
    logic        sevenseg_dp;
    logic [3:0]  sevenseg_enable;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;

    int multi    = 0;
    int bad_gap  = 0;
    int runs     = 0;
    int zeros    = 0;
    int ticks    = 0;
    logic [3:0] prev_en;

    // Expected pins for word 8F10 with dp=0001: digits 0,1,F,8 active-low.
    logic [6:0] s2_seg [4];
    logic [3:0] s2_dp_pin;

    sevenseg_scan_driver #(
        .N_DIGITS       (4),
        .PRESCALE       (8),
        .DEAD_CYCLES    (2),
        .SEG_ACTIVE_LOW (1),
        .EN_ACTIVE_LOW  (0)
    ) dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_value         (in_value),
        .in_dp            (in_dp),
        .in_blank         (in_blank),
        .sevenseg_segment (sevenseg_segment),
        .sevenseg_dp      (sevenseg_dp),
        .sevenseg_enable  (sevenseg_enable),
        .frame_tick       (frame_tick)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        t++;
    endtask

    task automatic run_to(input int target);
        while (t < target) step();
    endtask

    // One reset edge, check every output is inactive, then release; t restarts at 0.
    task automatic apply_reset();
        in_valid  = 1'b0;
        sys_rst_n = 1'b0;
        @(posedge sys_clk);
        #1;
        check_eq("rst_en",    32'(sevenseg_enable),  32'h0);
        check_eq("rst_seg",   32'(sevenseg_segment), 32'h7F);
        check_eq("rst_dp",    32'(sevenseg_dp),      32'h1);
        check_eq("rst_tick",  32'(frame_tick),       32'h0);
        check_eq("rst_ready", 32'(in_ready),         32'h0);
        sys_rst_n = 1'b1;
        t = 0;
    endtask

    // Enable pattern for 8-cycle slots with 2 dead cycles, shifted by the output register.
    function automatic logic [3:0] exp_en(input int tt);
        logic [3:0] r;
        int s;
        r = '0;
        if (tt > 0) begin
            s = tt - 1;
            if ((s % 8) >= 2) r[(s / 8) % 4] = 1'b1;
        end
        return r;
    endfunction

    task automatic offer(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        in_valid = 1'b1;
        in_value = v;
        in_dp    = dp;
        in_blank = bl;
    endtask

    initial begin
        int d;
        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        in_value  = '0;
        in_dp     = '0;
        in_blank  = '0;
        prev_en   = '0;
        s2_seg[0] = 7'h40;
        s2_seg[1] = 7'h79;
        s2_seg[2] = 7'h0E;
        s2_seg[3] = 7'h00;
        s2_dp_pin = 4'b1110;

        // Idle scan after reset: blank digits, rotating enables, tick every 32.
        apply_reset();
        step();
        check_eq("s1_ready_up", 32'(in_ready), 32'h1);
        while (t < 64) begin
            check_eq("s1_en",   32'(sevenseg_enable),  32'(exp_en(t)));
            check_eq("s1_seg",  32'(sevenseg_segment), 32'h7F);
            check_eq("s1_tick", 32'(frame_tick),       32'((t > 0) && (t % 32 == 0)));
            step();
        end

        // Word 8F10 accepted at cycle 5, shown from the next frame.
        apply_reset();
        run_to(5);
        check_eq("s2_ready_pre", 32'(in_ready), 32'h1);
        check_eq("s2_seg_old",   32'(sevenseg_segment), 32'h7F);
        offer(16'h8F10, 4'b0001, 4'b0000);
        step();
        in_valid = 1'b0;
        check_eq("s2_ready_held", 32'(in_ready), 32'h0);
        run_to(31);
        check_eq("s2_ready_31", 32'(in_ready), 32'h0);
        step();
        check_eq("s2_ready_32", 32'(in_ready), 32'h1);
        check_eq("s2_tick_32",  32'(frame_tick), 32'h1);
        check_eq("s2_seg_32",   32'(sevenseg_segment), 32'h7F);
        while (t < 64) begin
            step();
            d = ((t - 1) / 8) % 4;
            check_eq("s2_en", 32'(sevenseg_enable), 32'(exp_en(t)));
            if (exp_en(t) != 4'b0000) begin
                check_eq($sformatf("s2_seg_d%0d", d), 32'(sevenseg_segment), 32'(s2_seg[d]));
                check_eq($sformatf("s2_dp_d%0d", d),  32'(sevenseg_dp),      32'(s2_dp_pin[d]));
            end else begin
                check_eq("s2_seg_dead", 32'(sevenseg_segment), 32'h7F);
                check_eq("s2_dp_dead",  32'(sevenseg_dp),      32'h1);
            end
        end

        // Back-to-back words: 2222 waits for the boundary, 1111 shows exactly one frame.
        apply_reset();
        run_to(1);
        offer(16'h1111, 4'b0000, 4'b0000);
        step();
        check_eq("s3_ready_2", 32'(in_ready), 32'h0);
        offer(16'h2222, 4'b0000, 4'b0000);
        run_to(31);
        check_eq("s3_ready_31", 32'(in_ready), 32'h0);
        step();
        check_eq("s3_ready_32", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        check_eq("s3_ready_33", 32'(in_ready), 32'h0);
        run_to(35);
        check_eq("s3_seg_35", 32'(sevenseg_segment), 32'h79);
        check_eq("s3_dp_35",  32'(sevenseg_dp),      32'h1);
        run_to(59);
        check_eq("s3_seg_59", 32'(sevenseg_segment), 32'h79);
        run_to(64);
        check_eq("s3_en_64",  32'(sevenseg_enable),  32'h8);
        check_eq("s3_seg_64", 32'(sevenseg_segment), 32'h79);
        run_to(67);
        check_eq("s3_en_67",  32'(sevenseg_enable),  32'h1);
        check_eq("s3_seg_67", 32'(sevenseg_segment), 32'h24);
        run_to(91);
        check_eq("s3_seg_91", 32'(sevenseg_segment), 32'h24);

        // Accept on the boundary cycle itself: skips the upcoming frame.
        apply_reset();
        run_to(31);
        check_eq("s4_ready_31", 32'(in_ready), 32'h1);
        offer(16'hAAAA, 4'b0000, 4'b0000);
        step();
        in_valid = 1'b0;
        check_eq("s4_ready_32", 32'(in_ready), 32'h0);
        run_to(35);
        check_eq("s4_seg_35", 32'(sevenseg_segment), 32'h7F);
        run_to(59);
        check_eq("s4_seg_59", 32'(sevenseg_segment), 32'h7F);
        run_to(63);
        check_eq("s4_ready_63", 32'(in_ready), 32'h0);
        step();
        check_eq("s4_ready_64", 32'(in_ready), 32'h1);
        run_to(67);
        check_eq("s4_en_67",  32'(sevenseg_enable),  32'h1);
        check_eq("s4_seg_67", 32'(sevenseg_segment), 32'h08);

        // One-cycle reset mid-slot with a word pending: the word must be lost.
        apply_reset();
        run_to(1);
        offer(16'h5555, 4'b0000, 4'b0000);
        step();
        in_valid = 1'b0;
        check_eq("s5_ready_2", 32'(in_ready), 32'h0);
        run_to(12);
        check_eq("s5_en_12", 32'(sevenseg_enable), 32'h2);
        apply_reset();
        step();
        check_eq("s5_ready_1", 32'(in_ready), 32'h1);
        run_to(35);
        check_eq("s5_en_35",  32'(sevenseg_enable),  32'h1);
        check_eq("s5_seg_35", 32'(sevenseg_segment), 32'h7F);
        run_to(43);
        check_eq("s5_seg_43", 32'(sevenseg_segment), 32'h7F);

        // Ghosting: 1000 slots, at most one enable, exactly 2 dark cycles between digits.
        apply_reset();
        offer(16'h8888, 4'b0000, 4'b0000);
        run_to(2);
        in_valid = 1'b0;
        prev_en  = '0;
        while (t < 8000) begin
            step();
            if ($countones(sevenseg_enable) > 1) multi++;
            if (frame_tick) ticks++;
            if (sevenseg_enable == 4'b0000) begin
                zeros++;
            end else begin
                if (prev_en == 4'b0000) begin
                    runs++;
                    if (runs > 1 && zeros != 2) bad_gap++;
                end else if (sevenseg_enable != prev_en) begin
                    bad_gap++;
                end
                zeros = 0;
            end
            prev_en = sevenseg_enable;
        end
        check_eq("s6_multi",   32'(multi),   32'd0);
        check_eq("s6_gap",     32'(bad_gap), 32'd0);
        check_eq("s6_runs",    32'(runs),    32'd1000);
        check_eq("s6_ticks",   32'(ticks),   32'd250);
        check_eq("s6_en_end",  32'(sevenseg_enable),  32'h8);
        check_eq("s6_seg_end", 32'(sevenseg_segment), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
